// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: default geometry,
// register index type and named register indices.
package regfile_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

    localparam reg_idx_t R0 = 3'd0;
    localparam reg_idx_t R1 = 3'd1;
    localparam reg_idx_t R2 = 3'd2;
    localparam reg_idx_t R3 = 3'd3;
    localparam reg_idx_t R4 = 3'd4;
    localparam reg_idx_t R5 = 3'd5;
    localparam reg_idx_t R6 = 3'd6;
    localparam reg_idx_t R7 = 3'd7;

endpackage

// File: rtl/regfile_sb_if.sv
// Bus between the control/writeback side (master) and the register file (slave):
// write port, two read ports, reservation handshake and scoreboard status.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    localparam int DEPTH = 1 << ADDR_W;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              rbusy1;
    logic              rbusy2;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              rsv_ok;
    logic [DEPTH-1:0]  busy_vec;
    logic [ADDR_W:0]   busy_cnt;

    modport master (
        output we, waddr, wdata, raddr1, raddr2, rsv_en, rsv_addr,
        input  rdata1, rdata2, rbusy1, rbusy2, rsv_ok, busy_vec, busy_cnt
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2, rsv_en, rsv_addr,
        output rdata1, rdata2, rbusy1, rbusy2, rsv_ok, busy_vec, busy_cnt
    );

endinterface

// File: rtl/regfile_entry.sv
// One register of the file: data word with load enable plus its scoreboard
// busy flag. A set and a clear on the same edge leave the flag set.
module regfile_entry
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_i,
    input  logic [DATA_W-1:0] d_i,
    input  logic              busy_set_i,
    input  logic              busy_clr_i,
    output logic [DATA_W-1:0] q_o,
    output logic              busy_o
);

    logic [DATA_W-1:0] data_q;
    logic              busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            busy_q <= 1'b0;
        end else begin
            if (ld_i) begin
                data_q <= d_i;
            end
            if (busy_set_i) begin
                busy_q <= 1'b1;
            end else if (busy_clr_i) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign q_o    = data_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with one write port, two combinational read ports, optional
// write-to-read bypass, optional hardwired-zero R0 and a busy scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_sb_if.slave rf
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;

    logic              wr_is_zero;
    logic              rsv_is_zero;
    logic              wr_act;
    logic              rsv_ok;
    logic              set_act;
    logic              cnt_inc;
    logic              cnt_dec;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_d;

    // Everything combinational is gated by rst_n so outputs are quiet in reset.
    assign wr_is_zero  = ZERO_REG && (rf.waddr == '0);
    assign rsv_is_zero = ZERO_REG && (rf.rsv_addr == '0);
    assign wr_act      = rst_n & rf.we & ~wr_is_zero;

    assign rsv_ok = rst_n & rf.rsv_en &
                    (rsv_is_zero | ~busy[rf.rsv_addr] |
                     (wr_act & (rf.waddr == rf.rsv_addr)));

    // An accepted reservation to the zero register sets nothing.
    assign set_act = rsv_ok & ~rsv_is_zero;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            if (ZERO_REG && gi == 0) begin : g_zero
                assign regs[gi] = '0;
                assign busy[gi] = 1'b0;
            end else begin : g_reg
                logic set_hit;
                logic clr_hit;

                assign set_hit = set_act & (rf.rsv_addr == ADDR_W'(gi));
                assign clr_hit = wr_act & (rf.waddr == ADDR_W'(gi));

                regfile_entry #(
                    .DATA_W (DATA_W)
                ) u_entry (
                    .clk        (clk),
                    .rst_n      (rst_n),
                    .ld_i       (clr_hit),
                    .d_i        (rf.wdata),
                    .busy_set_i (set_hit),
                    .busy_clr_i (clr_hit),
                    .q_o        (regs[gi]),
                    .busy_o     (busy[gi])
                );
            end
        end
    endgenerate

    // Count only real transitions of busy bits so busy_cnt tracks popcount(busy).
    assign cnt_inc = set_act & ~busy[rf.rsv_addr];
    assign cnt_dec = wr_act & busy[rf.waddr] &
                     ~(set_act & (rf.rsv_addr == rf.waddr));

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc && !cnt_dec) begin
            cnt_d = cnt_q + 1'b1;
        end else if (cnt_dec && !cnt_inc) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    logic [ADDR_W-1:0] raddr_a [2];
    logic [DATA_W-1:0] rdata_a [2];
    logic              rbusy_a [2];

    assign raddr_a[0] = rf.raddr1;
    assign raddr_a[1] = rf.raddr2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rport
            logic byp;

            // wr_act already excludes the zero register and reset.
            assign byp         = BYPASS && wr_act && (rf.waddr == raddr_a[gi]);
            assign rdata_a[gi] = byp ? rf.wdata : regs[raddr_a[gi]];
            assign rbusy_a[gi] = byp ? 1'b0 : busy[raddr_a[gi]];
        end
    endgenerate

    assign rf.rdata1   = rdata_a[0];
    assign rf.rdata2   = rdata_a[1];
    assign rf.rbusy1   = rbusy_a[0];
    assign rf.rbusy2   = rbusy_a[1];
    assign rf.rsv_ok   = rsv_ok;
    assign rf.busy_vec = busy;
    assign rf.busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: one bypassing and one non-bypassing register file share the
// same stimulus; each step checks combinational and post-edge results.
module tb_regfile_sb;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    regfile_sb_if rf_a ();
    regfile_sb_if rf_b ();

    assign rf_b.we       = rf_a.we;
    assign rf_b.waddr    = rf_a.waddr;
    assign rf_b.wdata    = rf_a.wdata;
    assign rf_b.raddr1   = rf_a.raddr1;
    assign rf_b.raddr2   = rf_a.raddr2;
    assign rf_b.rsv_en   = rf_a.rsv_en;
    assign rf_b.rsv_addr = rf_a.rsv_addr;

    regfile_sb #(.ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf_a.slave)
    );

    regfile_sb #(.ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf_b.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rf_a.we       = 1'b0;
        rf_a.waddr    = R0;
        rf_a.wdata    = 8'h00;
        rf_a.raddr1   = R0;
        rf_a.raddr2   = R0;
        rf_a.rsv_en   = 1'b0;
        rf_a.rsv_addr = R0;
    endtask

    initial begin
        // Reset with active inputs: outputs must stay quiet
        rst_n = 1'b0;
        idle();
        rf_a.we = 1'b1; rf_a.waddr = R3; rf_a.wdata = 8'h5A; rf_a.raddr1 = R3;
        rf_a.rsv_en = 1'b1; rf_a.rsv_addr = R2;
        repeat (2) @(negedge clk);
        #1;
        $display("step: reset held with active inputs");
        check("rst_rsv_ok", 32'(rf_a.rsv_ok), 32'h0);
        check("rst_rdata1", 32'(rf_a.rdata1), 32'h0);
        check("rst_rbusy1", 32'(rf_a.rbusy1), 32'h0);
        check("rst_busy_vec", 32'(rf_a.busy_vec), 32'h0);
        check("rst_busy_cnt", 32'(rf_a.busy_cnt), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        idle();
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            rf_a.raddr1 = 3'(i);
            rf_a.raddr2 = 3'(i);
            #1;
            $display("step: post-reset read R%0d", i);
            check("init_rdata1", 32'(rf_a.rdata1), 32'h0);
            check("init_rbusy2", 32'(rf_a.rbusy2), 32'h0);
        end
        check("init_busy_cnt", 32'(rf_a.busy_cnt), 32'h0);

        // Write R3 with same-cycle read
        @(negedge clk);
        idle();
        rf_a.we = 1'b1; rf_a.waddr = R3; rf_a.wdata = 8'hA5; rf_a.raddr1 = R3;
        #1;
        $display("step: write R3=A5, same-cycle read");
        check("wr_byp_rdata1", 32'(rf_a.rdata1), 32'hA5);
        check("wr_nobyp_rdata1", 32'(rf_b.rdata1), 32'h00);
        @(negedge clk);
        idle();
        rf_a.raddr1 = R3;
        #1;
        $display("step: read R3 after edge");
        check("rd_a_rdata1", 32'(rf_a.rdata1), 32'hA5);
        check("rd_b_rdata1", 32'(rf_b.rdata1), 32'hA5);

        // Reset asserted mid-write
        @(negedge clk);
        rf_a.we = 1'b1; rf_a.waddr = R6; rf_a.wdata = 8'h77;
        rst_n = 1'b0;
        #1;
        $display("step: reset mid-write");
        check("midrst_rdata1", 32'(rf_a.rdata1), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        rf_a.raddr1 = R6;
        rf_a.raddr2 = R3;
        #1;
        check("midrst_r6", 32'(rf_a.rdata1), 32'h00);
        check("midrst_r3", 32'(rf_a.rdata2), 32'h00);

        // Zero register: write and reserve
        @(negedge clk);
        idle();
        rf_a.we = 1'b1; rf_a.waddr = R0; rf_a.wdata = 8'hFF;
        rf_a.rsv_en = 1'b1; rf_a.rsv_addr = R0; rf_a.raddr1 = R0;
        #1;
        $display("step: write R0=FF and reserve R0");
        check("r0_rsv_ok", 32'(rf_a.rsv_ok), 32'h1);
        check("r0_byp_rdata1", 32'(rf_a.rdata1), 32'h00);
        @(negedge clk);
        idle();
        #1;
        check("r0_rdata1", 32'(rf_a.rdata1), 32'h00);
        check("r0_rbusy1", 32'(rf_a.rbusy1), 32'h0);
        check("r0_busy_vec", 32'(rf_a.busy_vec), 32'h00);
        check("r0_busy_cnt", 32'(rf_a.busy_cnt), 32'h0);

        // Reserve R5, retry refused, then writeback clears
        @(negedge clk);
        idle();
        rf_a.rsv_en = 1'b1; rf_a.rsv_addr = R5; rf_a.raddr1 = R5;
        #1;
        $display("step: reserve R5");
        check("r5_rsv_ok", 32'(rf_a.rsv_ok), 32'h1);
        check("r5_rbusy_pre", 32'(rf_a.rbusy1), 32'h0);
        @(negedge clk);
        rf_a.rsv_en = 1'b1; rf_a.rsv_addr = R5; rf_a.raddr1 = R5;
        #1;
        $display("step: reserve R5 again");
        check("r5_rbusy", 32'(rf_a.rbusy1), 32'h1);
        check("r5_busy_cnt", 32'(rf_a.busy_cnt), 32'h1);
        check("r5_busy_vec", 32'(rf_a.busy_vec), 32'h20);
        check("r5_rsv_refused", 32'(rf_a.rsv_ok), 32'h0);
        @(negedge clk);
        idle();
        rf_a.we = 1'b1; rf_a.waddr = R5; rf_a.wdata = 8'h3C; rf_a.raddr1 = R5;
        #1;
        $display("step: write R5=3C");
        check("r5_refused_cnt", 32'(rf_a.busy_cnt), 32'h1);
        check("r5_byp_rdata1", 32'(rf_a.rdata1), 32'h3C);
        check("r5_byp_rbusy1", 32'(rf_a.rbusy1), 32'h0);
        check("r5_nobyp_rbusy1", 32'(rf_b.rbusy1), 32'h1);
        check("r5_nobyp_rdata1", 32'(rf_b.rdata1), 32'h00);
        @(negedge clk);
        idle();
        rf_a.raddr1 = R5;
        #1;
        check("r5_wb_rdata1", 32'(rf_a.rdata1), 32'h3C);
        check("r5_wb_rbusy1", 32'(rf_a.rbusy1), 32'h0);
        check("r5_wb_busy_cnt", 32'(rf_a.busy_cnt), 32'h0);
        check("r5_wb_b_rdata1", 32'(rf_b.rdata1), 32'h3C);

        // R2 busy, then write and re-reserve R2 on the same edge
        @(negedge clk);
        idle();
        rf_a.rsv_en = 1'b1; rf_a.rsv_addr = R2;
        #1;
        $display("step: reserve R2");
        check("r2_rsv_ok", 32'(rf_a.rsv_ok), 32'h1);
        @(negedge clk);
        idle();
        rf_a.we = 1'b1; rf_a.waddr = R2; rf_a.wdata = 8'h11;
        rf_a.rsv_en = 1'b1; rf_a.rsv_addr = R2; rf_a.raddr2 = R2;
        #1;
        $display("step: write R2=11 and reserve R2");
        check("r2_same_rsv_ok", 32'(rf_a.rsv_ok), 32'h1);
        check("r2_same_cnt_pre", 32'(rf_a.busy_cnt), 32'h1);
        check("r2_byp_rdata2", 32'(rf_a.rdata2), 32'h11);
        check("r2_byp_rbusy2", 32'(rf_a.rbusy2), 32'h0);
        @(negedge clk);
        idle();
        rf_a.raddr1 = R2;
        #1;
        check("r2_rdata1", 32'(rf_a.rdata1), 32'h11);
        check("r2_rbusy1", 32'(rf_a.rbusy1), 32'h1);
        check("r2_busy_cnt", 32'(rf_a.busy_cnt), 32'h1);
        @(negedge clk);
        idle();
        rf_a.we = 1'b1; rf_a.waddr = R2; rf_a.wdata = 8'h22;
        @(negedge clk);
        idle();
        #1;
        $display("step: writeback R2=22");
        check("r2_clr_busy_cnt", 32'(rf_a.busy_cnt), 32'h0);
        check("r2_clr_busy_vec", 32'(rf_a.busy_vec), 32'h00);

        // Reserve R1..R7 back to back
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            idle();
            rf_a.rsv_en = 1'b1;
            rf_a.rsv_addr = 3'(i);
            #1;
            $display("step: reserve R%0d", i);
            check("fill_rsv_ok", 32'(rf_a.rsv_ok), 32'h1);
        end
        @(negedge clk);
        idle();
        #1;
        check("fill_busy_cnt", 32'(rf_a.busy_cnt), 32'h7);
        check("fill_busy_vec", 32'(rf_a.busy_vec), 32'hFE);

        // Clear and reserve R4 on the same edge
        @(negedge clk);
        idle();
        rf_a.we = 1'b1; rf_a.waddr = R4; rf_a.wdata = 8'h44;
        rf_a.rsv_en = 1'b1; rf_a.rsv_addr = R4;
        #1;
        $display("step: write R4=44 and reserve R4");
        check("r4_rsv_ok", 32'(rf_a.rsv_ok), 32'h1);
        @(negedge clk);
        idle();
        rf_a.raddr2 = R4;
        #1;
        check("r4_busy_cnt", 32'(rf_a.busy_cnt), 32'h7);
        check("r4_busy_vec", 32'(rf_a.busy_vec), 32'hFE);
        check("r4_rdata2", 32'(rf_a.rdata2), 32'h44);
        check("r4_rbusy2", 32'(rf_a.rbusy2), 32'h1);

        // Clear R1 while a refused reservation targets busy R6
        @(negedge clk);
        idle();
        rf_a.we = 1'b1; rf_a.waddr = R1; rf_a.wdata = 8'h01;
        rf_a.rsv_en = 1'b1; rf_a.rsv_addr = R6;
        #1;
        $display("step: write R1=01, reserve busy R6");
        check("r6_rsv_refused", 32'(rf_a.rsv_ok), 32'h0);
        @(negedge clk);
        idle();
        #1;
        check("r1_clr_busy_cnt", 32'(rf_a.busy_cnt), 32'h6);
        check("r1_clr_busy_vec", 32'(rf_a.busy_vec), 32'hFC);
        check("r1_clr_b_busy_cnt", 32'(rf_b.busy_cnt), 32'h6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with one write port, two asynchronous read ports, optional write-to-read bypass, hardwired-zero register 0 and a per-register busy scoreboard with reservation handshake. It replaces the fixed 8×8 register file in the datapath. The control unit reserves a destination at issue and the writeback stage clears the reservation. Read ports also report whether the operand is still pending.

## Interface
- DATA_W, 8, register width in bits
- ADDR_W, 3, index width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, if 1 register 0 reads 0, ignores writes and never becomes busy
- BYPASS, 1, if 1 a same-cycle write is forwarded to matching read ports

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous reset, active-low
- we  in  1  write enable
- waddr  in  ADDR_W  write index
- wdata  in  DATA_W  write data
- raddr1, raddr2  in  ADDR_W  read indices
- rdata1, rdata2  out  DATA_W  read data
- rbusy1, rbusy2  out  1  addressed register has an outstanding reservation
- rsv_en  in  1  reservation request
- rsv_addr  in  ADDR_W  register to reserve
- rsv_ok  out  1  reservation accepted this cycle (combinational)
- busy_vec  out  DEPTH  scoreboard bits
- busy_cnt  out  ADDR_W+1  number of set busy bits

## Operation
- Reset (rst=0, asynchronous): all registers 0, busy_vec 0, busy_cnt 0. Outputs are then rdata*=0, rbusy*=0, rsv_ok=0 regardless of inputs.
- Write: if we=1 and waddr is not the zero register, regs[waddr] <= wdata and busy[waddr] <= 0. Writes to non-busy registers are legal.
- Reservation: rsv_ok = rsv_en & (~busy[rsv_addr] | (we & waddr==rsv_addr)). On rsv_ok, busy[rsv_addr] <= 1. A refused request changes nothing; the requester retries.
- Write and reservation to the same index in the same cycle: the data is written and busy ends at 1, so the new reservation wins.
- Zero register (ZERO_REG=1): reservation to index 0 gives rsv_ok=rsv_en, with busy[0] held 0. rdata=0 and rbusy=0 always.
- Read: rdata = regs[raddr] and rbusy = busy[raddr], both combinational.
- Bypass (BYPASS=1), when we=1, waddr==raddr and the index is not the zero register: rdata=wdata and rbusy=0.
- With BYPASS=0, reads return pre-edge contents.
- busy_cnt is a registered counter, updated per edge by (+1 on set) (−1 on clear). A same-edge clear of index A and set of index B gives net 0. A same-index clear and set gives net 0.
- busy_cnt always equals popcount(busy_vec). It never wraps: maximum DEPTH, or DEPTH−1 with ZERO_REG.

## Timing
- Write and reservation take effect at the first rising edge after the request, with 1-cycle visibility on non-bypassed reads.
- Read latency is 0 cycles, combinational.
- rsv_ok is valid in the same cycle as rsv_en; it has no registered acknowledge.
- Reset deassertion is synchronised externally. The first edge after rst rises performs normal updates.
- Reset asserted mid-operation discards pending reservations and data immediately.

## Structure
- Shared package regfile_pkg holds:
  - the default DATA_W and ADDR_W
  - the named register indices R0..R7 as constants
  - the typedef reg_idx_t
- Sub-module regfile_entry: one DATA_W register with load enable and async active-low clear, plus its busy flop with set/clear inputs. It is instantiated DEPTH times with a generate loop; index 0 is tied off when ZERO_REG=1.
- Read muxes, bypass, rsv_ok logic and busy_cnt live in the top.

## Test plan
- Reset, then read R1..R7 → rdata=0x00, rbusy=0, busy_cnt=0. Assert rst=0 mid-write → next read 0x00.
- Write R3=0xA5, next cycle raddr1=3 → rdata1=0xA5. Same cycle as write with BYPASS=1 → rdata1=0xA5; with BYPASS=0 → old value 0x00.
- Write R0=0xFF, reserve R0 → rdata=0x00, rsv_ok=1, busy_vec[0]=0, busy_cnt unchanged.
- Reserve R5 → rsv_ok=1, next cycle rbusy=1 and busy_cnt=1. Reserve R5 again → rsv_ok=0. Write R5=0x3C → rbusy=0, busy_cnt=0, rdata=0x3C.
- With R2 busy, same cycle write R2=0x11 and reserve R2 → rsv_ok=1, next cycle rdata=0x11, rbusy=1, busy_cnt=1.
- Reserve R1..R7 on consecutive cycles → busy_cnt=7, busy_vec=8'hFE. Clear R4 and reserve R4 on the same edge → busy_cnt stays 7.
